core_msg_rx: RTL and testbench
==============================

# core_msg_rx

Core-side receiver for the scheduler-to-core load protocol. Each shader core has one instance. It watches the broadcast 16-bit message bus and its four load strobes, determines whether its core is selected, and unpacks R0 operand words and one instruction frame into the core's local register and instruction memories. It then hands the frame to the core pipeline and reports `core_ready` / `core_reading` back to the scheduler.

## Interface
Parameters:
- `CORE_ID`, 0: index of this core; selects bit `CORE_ID` of the core-mask word.
- `CORE_NUM`, 16: cores on the bus; core-mask width.
- `BUS_W`, 16: message bus width.
- `R0_DEPTH`, 8: R0 registers per core; R0-mask width.
- `FRAME_SIZE`, 16: instruction words per frame.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `mess_bus`  in  BUS_W  broadcast message word.
- `core_mask_loading`  in  1  `mess_bus` carries the core-select mask.
- `r0_mask_loading`  in  1  `mess_bus[R0_DEPTH-1:0]` carries the R0 load mask.
- `r0_loading`  in  1  `mess_bus` carries one R0 data word.
- `instr_loading`  in  1  `mess_bus` carries one instruction word.
- `exec_done`  in  1  the core pipeline has finished the current frame.
- `r0_we`  out  1  R0 write enable.
- `r0_waddr`  out  clog2(R0_DEPTH)  R0 write index.
- `r0_wdata`  out  BUS_W  R0 write data.
- `imem_we`  out  1  instruction memory write enable.
- `imem_waddr`  out  clog2(FRAME_SIZE)  instruction write index.
- `imem_wdata`  out  BUS_W  instruction write data.
- `start`  out  1  one-cycle pulse that launches the pipeline.
- `core_ready`  out  1  core is idle and may be selected.
- `core_reading`  out  1  frame fully consumed; the scheduler may overwrite its buffer.
- `proto_err`  out  1  sticky protocol error.

## Operation
- Per-frame bus sequence: 1 core-mask word; 1 R0-mask word; popcount(R0 mask) R0 words; FRAME_SIZE instruction words. Each word is valid for exactly one cycle while its strobe is high. Strobes may have gaps between them.
- States:
  - IDLE: `core_ready`=1.
    - `core_mask_loading` with own bit set -> R0MASK.
    - `core_mask_loading` with own bit clear -> SKIP.
    - All other strobes are ignored.
  - SKIP: ignores every strobe except `core_mask_loading`, which is evaluated exactly as in IDLE.
  - R0MASK: on `r0_mask_loading`, latch the mask.
    - Mask nonzero -> R0DATA.
    - Mask zero -> INSTR.
  - R0DATA: each `r0_loading` word is written to the lowest set bit of the remaining mask, and that bit is then cleared. When the mask becomes zero -> INSTR.
  - INSTR: each `instr_loading` word is written at an index counting 0..FRAME_SIZE-1. After the last word -> RUN, `start` pulses.
  - RUN: `core_reading`=1 and `core_ready`=0. On `exec_done` -> IDLE, and `core_reading` clears on entry to IDLE.
- A strobe that arrives out of order is a protocol error:
  - In R0MASK, R0DATA or INSTR: ignored, except `core_mask_loading`, which aborts the partial load and is re-evaluated as in IDLE.
  - In RUN: `core_mask_loading` with own bit set is ignored.
- More than one strobe high in the same cycle is a protocol error, and the word is dropped.

## Timing
- Reset values: state = IDLE; all `*_we`, `start`, `core_reading` and `proto_err` = 0; `core_ready` = 1; address and data outputs = 0; counter and mask = 0.
- Inputs are sampled at the rising edge. Write-port outputs are registered, so the write for a word sampled in cycle n appears in cycle n+1 for one cycle.
- `start` and `core_reading` rise in the same cycle as the last `imem_we`.
- `core_ready` falls the cycle after the selecting core-mask word is sampled.
- `exec_done` in RUN: IDLE and `core_ready`=1 in the next cycle.
- `exec_done` outside RUN is ignored.
- Minimum frame, with back-to-back words and a zero R0 mask: 2 + FRAME_SIZE cycles from the core-mask word to `start`.
- The instruction counter wraps to 0 after FRAME_SIZE-1 and resets on every new selection.
- Reset mid-load: every output returns to its reset value the next cycle. No partial write completes after reset.

## Configuration
- `CORE_MSG_RX_ERR_EN` defined: all protocol-error cases set `proto_err`, which stays at 1 until reset.
- Not defined: `proto_err` is tied to 0 and the error-check logic is not synthesized. Out-of-order words are still dropped exactly as specified in Operation.

## Structure
- Shared package `gpu_msg_pkg`:
  - state enum (IDLE, SKIP, R0MASK, R0DATA, INSTR, RUN);
  - default widths `BUS_W`, `CORE_NUM`, `R0_DEPTH`, `FRAME_SIZE`;
  - function for the R0 index width.
- Sub-module `lsb_prio_enc`: R0_DEPTH-bit lowest-set-bit encoder with a valid output. It drives `r0_waddr`.

## Test plan
- CORE_ID=3, core mask 0x0008, R0 mask 0x05, R0 words 0xAAAA and 0xBBBB, instruction words 0x0100..0x010F.
  - R0 writes: 0xAAAA to index 0, then 0xBBBB to index 2.
  - Instruction writes: indices 0..15 in order.
  - `start` pulses once, and `core_reading`=1.
  - `exec_done` -> `core_ready`=1 the next cycle.
- Core mask 0x0004 (CORE_ID=3), then a full frame: no writes, `core_ready` stays 1. A following frame with mask 0x0008 loads normally.
- R0 mask 0x00: the first instruction word after it is written to `imem_waddr`=0, and no `r0_we` occurs.
- New core mask 0x0008 after 5 instruction words: the partial load aborts, `proto_err`=1 (macro defined), and the full new frame then loads from index 0.
- `r0_loading` and `instr_loading` high in the same cycle: no write, `proto_err`=1. With the macro undefined: `proto_err`=0 and still no write.
- `reset` during R0DATA: the next cycle shows state IDLE, `core_ready`=1, and no further `r0_we`.

Source files
------------

// File: rtl/gpu_msg_pkg.sv
// rtl/gpu_msg_pkg.sv - shared widths, receiver states and index-width helper for the core load protocol
package gpu_msg_pkg;

    localparam int DEF_BUS_W      = 16;
    localparam int DEF_CORE_NUM   = 16;
    localparam int DEF_R0_DEPTH   = 8;
    localparam int DEF_FRAME_SIZE = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SKIP   = 3'd1,
        ST_R0MASK = 3'd2,
        ST_R0DATA = 3'd3,
        ST_INSTR  = 3'd4,
        ST_RUN    = 3'd5
    } msg_state_e;

    // Index width for a memory of the given depth; never narrower than one bit.
    function automatic int idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/lsb_prio_enc.sv
// rtl/lsb_prio_enc.sv - lowest-set-bit priority encoder with valid flag
module lsb_prio_enc
    import gpu_msg_pkg::*;
#(
    parameter int W = DEF_R0_DEPTH
) (
    input  logic [W-1:0]        req,
    output logic [idx_w(W)-1:0] idx,
    output logic                valid
);

    localparam int IW = idx_w(W);

    // Scanning downward lets the lowest set bit overwrite any higher one.
    always_comb begin
        idx = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IW'(i);
            end
        end
    end

    assign valid = |req;

endmodule

// File: rtl/core_msg_rx.sv
// rtl/core_msg_rx.sv - core-side frame receiver; CORE_MSG_RX_ERR_EN enables the sticky proto_err flag
module core_msg_rx
    import gpu_msg_pkg::*;
#(
    parameter int CORE_ID    = 0,
    parameter int CORE_NUM   = DEF_CORE_NUM,
    parameter int BUS_W      = DEF_BUS_W,
    parameter int R0_DEPTH   = DEF_R0_DEPTH,
    parameter int FRAME_SIZE = DEF_FRAME_SIZE
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [BUS_W-1:0]              mess_bus,
    input  logic                          core_mask_loading,
    input  logic                          r0_mask_loading,
    input  logic                          r0_loading,
    input  logic                          instr_loading,
    input  logic                          exec_done,
    output logic                          r0_we,
    output logic [idx_w(R0_DEPTH)-1:0]    r0_waddr,
    output logic [BUS_W-1:0]              r0_wdata,
    output logic                          imem_we,
    output logic [idx_w(FRAME_SIZE)-1:0]  imem_waddr,
    output logic [BUS_W-1:0]              imem_wdata,
    output logic                          start,
    output logic                          core_ready,
    output logic                          core_reading,
    output logic                          proto_err
);

    localparam int RW = idx_w(R0_DEPTH);
    localparam int IW = idx_w(FRAME_SIZE);
    localparam logic [CORE_NUM-1:0] OWN_BIT = CORE_NUM'(1) << CORE_ID;

    msg_state_e          state;
    logic [R0_DEPTH-1:0] r0_mask;
    logic [R0_DEPTH-1:0] r0_mask_rest;
    logic [IW-1:0]       instr_cnt;
    logic [RW-1:0]       enc_idx;
    logic                enc_valid;
    logic [3:0]          strb;
    logic                single;
    logic                cm, rm, rd, il;
    logic                own_sel;

    // A word counts only when exactly one strobe is high; collisions drop it.
    assign strb   = {core_mask_loading, r0_mask_loading, r0_loading, instr_loading};
    assign single = $onehot(strb);
    assign cm     = single & core_mask_loading;
    assign rm     = single & r0_mask_loading;
    assign rd     = single & r0_loading;
    assign il     = single & instr_loading;

    assign own_sel      = |(mess_bus[CORE_NUM-1:0] & OWN_BIT);
    assign r0_mask_rest = r0_mask & (r0_mask - 1'b1);

    lsb_prio_enc #(.W(R0_DEPTH)) u_enc (
        .req   (r0_mask),
        .idx   (enc_idx),
        .valid (enc_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            r0_mask    <= '0;
            instr_cnt  <= '0;
            r0_we      <= 1'b0;
            r0_waddr   <= '0;
            r0_wdata   <= '0;
            imem_we    <= 1'b0;
            imem_waddr <= '0;
            imem_wdata <= '0;
            start      <= 1'b0;
        end else begin
            r0_we   <= 1'b0;
            imem_we <= 1'b0;
            start   <= 1'b0;
            // A core-mask word outside RUN always restarts selection, aborting any partial load.
            if (cm && state != ST_RUN) begin
                state     <= own_sel ? ST_R0MASK : ST_SKIP;
                r0_mask   <= '0;
                instr_cnt <= '0;
            end else begin
                case (state)
                    ST_R0MASK: if (rm) begin
                        r0_mask <= mess_bus[R0_DEPTH-1:0];
                        state   <= (|mess_bus[R0_DEPTH-1:0]) ? ST_R0DATA : ST_INSTR;
                    end
                    ST_R0DATA: if (rd && enc_valid) begin
                        r0_we    <= 1'b1;
                        r0_waddr <= enc_idx;
                        r0_wdata <= mess_bus;
                        r0_mask  <= r0_mask_rest;
                        if (r0_mask_rest == '0) begin
                            state <= ST_INSTR;
                        end
                    end
                    ST_INSTR: if (il) begin
                        imem_we    <= 1'b1;
                        imem_waddr <= instr_cnt;
                        imem_wdata <= mess_bus;
                        if (instr_cnt == IW'(FRAME_SIZE - 1)) begin
                            instr_cnt <= '0;
                            state     <= ST_RUN;
                            start     <= 1'b1;
                        end else begin
                            instr_cnt <= instr_cnt + 1'b1;
                        end
                    end
                    ST_RUN: if (exec_done) begin
                        state <= ST_IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign core_ready   = (state == ST_IDLE) || (state == ST_SKIP);
    assign core_reading = (state == ST_RUN);

`ifdef CORE_MSG_RX_ERR_EN
    logic err_evt;

    always_comb begin
        err_evt = 1'b0;
        if ((|strb) && !single) begin
            err_evt = 1'b1;
        end else if (single) begin
            case (state)
                ST_R0MASK: err_evt = !r0_mask_loading;
                ST_R0DATA: err_evt = !r0_loading;
                ST_INSTR:  err_evt = !instr_loading;
                ST_RUN:    err_evt = core_mask_loading && own_sel;
                default:   err_evt = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            proto_err <= 1'b0;
        end else if (err_evt) begin
            proto_err <= 1'b1;
        end
    end
`else
    assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_core_msg_rx.sv
// tb/tb_core_msg_rx.sv - randomized and directed self-checking bench for core_msg_rx
module tb_core_msg_rx;

    localparam int CORE_ID = 3;
    localparam int FRAME   = 16;
`ifdef CORE_MSG_RX_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] mess_bus = '0;
    logic        core_mask_loading = 1'b0;
    logic        r0_mask_loading = 1'b0;
    logic        r0_loading = 1'b0;
    logic        instr_loading = 1'b0;
    logic        exec_done = 1'b0;
    logic        r0_we;
    logic [2:0]  r0_waddr;
    logic [15:0] r0_wdata;
    logic        imem_we;
    logic [3:0]  imem_waddr;
    logic [15:0] imem_wdata;
    logic        start;
    logic        core_ready;
    logic        core_reading;
    logic        proto_err;

    core_msg_rx #(.CORE_ID(CORE_ID)) dut (
        .clk               (clk),
        .reset             (reset),
        .mess_bus          (mess_bus),
        .core_mask_loading (core_mask_loading),
        .r0_mask_loading   (r0_mask_loading),
        .r0_loading        (r0_loading),
        .instr_loading     (instr_loading),
        .exec_done         (exec_done),
        .r0_we             (r0_we),
        .r0_waddr          (r0_waddr),
        .r0_wdata          (r0_wdata),
        .imem_we           (imem_we),
        .imem_waddr        (imem_waddr),
        .imem_wdata        (imem_wdata),
        .start             (start),
        .core_ready        (core_ready),
        .core_reading      (core_reading),
        .proto_err         (proto_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc_no   = 0;

    // Reference model: a selected frame is a list of expected words.
    bit m_sel, m_mask_seen, m_run, m_err;
    int m_pend[$];
    int m_icnt;
    bit e_r0_we, e_imem_we, e_start;
    int e_r0_waddr, e_r0_wdata, e_imem_waddr, e_imem_wdata;

    int r0_log_addr[$], r0_log_data[$], im_log_addr[$], im_log_data[$];
    int start_cnt = 0;
    int last_start_cyc = -1;
    bit ready_dropped = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc_no);
        end
    endtask

    task automatic model_select(input logic [15:0] bus);
        m_sel       = bus[CORE_ID];
        m_mask_seen = 0;
        m_pend.delete();
        m_icnt      = 0;
    endtask

    task automatic model_reset();
        m_sel = 0; m_mask_seen = 0; m_run = 0; m_err = 0; m_icnt = 0;
        m_pend.delete();
        e_r0_we = 0; e_imem_we = 0; e_start = 0;
    endtask

    task automatic model_step(input bit cm, input bit rm, input bit rd, input bit il,
                              input logic [15:0] bus, input bit ex);
        int n;
        bit was_run, bad;
        n = int'(cm) + int'(rm) + int'(rd) + int'(il);
        was_run = m_run;
        bad = 0;
        e_r0_we = 0; e_imem_we = 0; e_start = 0;
        if (was_run && ex) m_run = 0;
        if (n > 1) begin
            bad = 1;
        end else if (n == 1) begin
            if (was_run) begin
                if (cm && bus[CORE_ID]) bad = 1;
            end else if (m_sel) begin
                if (cm) begin
                    bad = 1;
                    model_select(bus);
                end else if (!m_mask_seen) begin
                    if (rm) begin
                        m_mask_seen = 1;
                        for (int i = 0; i < 8; i++) if (bus[i]) m_pend.push_back(i);
                    end else bad = 1;
                end else if (m_pend.size() > 0) begin
                    if (rd) begin
                        e_r0_we = 1;
                        e_r0_waddr = m_pend.pop_front();
                        e_r0_wdata = int'(bus);
                    end else bad = 1;
                end else begin
                    if (il) begin
                        e_imem_we = 1;
                        e_imem_waddr = m_icnt;
                        e_imem_wdata = int'(bus);
                        m_icnt++;
                        if (m_icnt == FRAME) begin
                            m_sel = 0; m_run = 1; e_start = 1; m_icnt = 0;
                        end
                    end else bad = 1;
                end
            end else if (cm) begin
                model_select(bus);
            end
        end
        if (bad && ERR_EN) m_err = 1;
    endtask

    task automatic check_outputs();
        chk("r0_we", r0_we, e_r0_we);
        chk("imem_we", imem_we, e_imem_we);
        chk("start", start, e_start);
        chk("core_ready", core_ready, !m_sel && !m_run);
        chk("core_reading", core_reading, m_run);
        chk("proto_err", proto_err, m_err);
        if (e_r0_we) begin
            chk("r0_waddr", r0_waddr, e_r0_waddr);
            chk("r0_wdata", r0_wdata, e_r0_wdata);
        end
        if (e_imem_we) begin
            chk("imem_waddr", imem_waddr, e_imem_waddr);
            chk("imem_wdata", imem_wdata, e_imem_wdata);
        end
        if (r0_we) begin
            r0_log_addr.push_back(int'(r0_waddr));
            r0_log_data.push_back(int'(r0_wdata));
        end
        if (imem_we) begin
            im_log_addr.push_back(int'(imem_waddr));
            im_log_data.push_back(int'(imem_wdata));
        end
        if (start) begin
            start_cnt++;
            last_start_cyc = cyc_no + 1;
        end
        if (!core_ready) ready_dropped = 1;
    endtask

    task automatic clear_logs();
        r0_log_addr.delete(); r0_log_data.delete();
        im_log_addr.delete(); im_log_data.delete();
        start_cnt = 0; ready_dropped = 0;
    endtask

    task automatic step(input bit cm, input bit rm, input bit rd, input bit il,
                        input logic [15:0] bus, input bit ex);
        core_mask_loading = cm; r0_mask_loading = rm; r0_loading = rd; instr_loading = il;
        mess_bus = bus; exec_done = ex;
        model_step(cm, rm, rd, il, bus, ex);
        @(posedge clk); #1;
        cyc_no++;
        check_outputs();
    endtask

    task automatic rst_step(input bit rd_on);
        reset = 1; r0_loading = rd_on; core_mask_loading = 0; r0_mask_loading = 0;
        instr_loading = 0; exec_done = 0; mess_bus = 16'h2222;
        model_reset();
        @(posedge clk); #1;
        cyc_no++;
        check_outputs();
        reset = 0;
    endtask

    task automatic gap(input int maxgap);
        repeat ($urandom_range(0, maxgap)) step(0, 0, 0, 0, 16'($urandom), ($urandom % 8) == 0);
    endtask

    task automatic noise();
        logic [3:0] v;
        if (($urandom % 20) == 0) begin
            v = 4'($urandom);
            step(v[3], v[2], v[1], v[0], 16'($urandom), ($urandom % 8) == 0);
        end
    endtask

    task automatic send_frame(input logic [15:0] cmask, input logic [7:0] rmask,
                              input logic [15:0] ibase, input int maxgap, input bit noisy);
        step(1, 0, 0, 0, cmask, 0); gap(maxgap);
        if (noisy) noise();
        step(0, 1, 0, 0, {8'h00, rmask}, 0); gap(maxgap);
        for (int i = 0; i < $countones(rmask); i++) begin
            if (noisy) noise();
            step(0, 0, 1, 0, 16'hA000 + 16'(i), 0); gap(maxgap);
        end
        for (int i = 0; i < FRAME; i++) begin
            if (noisy) noise();
            step(0, 0, 0, 1, ibase + 16'(i), 0); gap(maxgap);
        end
    endtask

    initial begin
        int mask_cyc;
        logic [15:0] cm_word;

        // Reset state
        step(0, 0, 0, 0, 16'h0000, 0);
        rst_step(0);
        chk("rst_core_ready", core_ready, 1);
        chk("rst_core_reading", core_reading, 0);
        chk("rst_start", start, 0);
        chk("rst_proto_err", proto_err, 0);
        chk("rst_r0_waddr", r0_waddr, 0);
        chk("rst_imem_waddr", imem_waddr, 0);

        // Basic frame: R0 mask 0x05 writes index 0 then 2
        clear_logs();
        step(1, 0, 0, 0, 16'h0008, 0);
        step(0, 1, 0, 0, 16'h0005, 0);
        step(0, 0, 1, 0, 16'hAAAA, 0);
        step(0, 0, 1, 0, 16'hBBBB, 0);
        for (int i = 0; i < FRAME; i++) step(0, 0, 0, 1, 16'h0100 + 16'(i), 0);
        chk("t1_r0_count", r0_log_addr.size(), 2);
        if (r0_log_addr.size() >= 2) begin
            chk("t1_r0_addr0", r0_log_addr[0], 0);
            chk("t1_r0_data0", r0_log_data[0], 16'hAAAA);
            chk("t1_r0_addr1", r0_log_addr[1], 2);
            chk("t1_r0_data1", r0_log_data[1], 16'hBBBB);
        end
        chk("t1_imem_count", im_log_addr.size(), FRAME);
        for (int i = 0; i < im_log_addr.size(); i++) begin
            chk("t1_imem_addr", im_log_addr[i], i);
            chk("t1_imem_data", im_log_data[i], 16'h0100 + i);
        end
        chk("t1_start_count", start_cnt, 1);
        chk("t1_reading", core_reading, 1);
        chk("t1_not_ready", core_ready, 0);
        step(0, 0, 0, 0, 16'h0000, 0);
        step(0, 0, 0, 0, 16'h0000, 1);
        chk("t1_ready_after_exec", core_ready, 1);

        // Zero R0 mask, back-to-back: minimum latency and first write at index 0
        clear_logs();
        step(1, 0, 0, 0, 16'h0008, 0);
        mask_cyc = cyc_no;
        step(0, 1, 0, 0, 16'h0000, 0);
        for (int i = 0; i < FRAME; i++) step(0, 0, 0, 1, 16'h0300 + 16'(i), 0);
        chk("t3_latency", last_start_cyc - mask_cyc, 2 + FRAME);
        chk("t3_no_r0", r0_log_addr.size(), 0);
        chk("t3_imem_count", im_log_addr.size(), FRAME);
        if (im_log_addr.size() > 0) chk("t3_first_addr", im_log_addr[0], 0);
        step(0, 0, 0, 0, 16'h0000, 1);

        // Not selected: the whole frame is skipped, then a selecting frame loads
        clear_logs();
        send_frame(16'h0004, 8'h05, 16'h0400, 1, 0);
        chk("t2_skip_r0", r0_log_addr.size(), 0);
        chk("t2_skip_imem", im_log_addr.size(), 0);
        chk("t2_ready_held", ready_dropped, 0);
        clear_logs();
        send_frame(16'h0008, 8'h05, 16'h0500, 1, 0);
        chk("t2_load_r0", r0_log_addr.size(), 2);
        chk("t2_load_imem", im_log_addr.size(), FRAME);
        step(0, 0, 0, 0, 16'h0000, 1);

        // Abort after 5 instruction words, then a full frame from index 0
        rst_step(0);
        step(1, 0, 0, 0, 16'h0008, 0);
        step(0, 1, 0, 0, 16'h0000, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 16'h0600 + 16'(i), 0);
        clear_logs();
        step(1, 0, 0, 0, 16'h0008, 0);
        chk("t4_abort_err", proto_err, ERR_EN);
        step(0, 1, 0, 0, 16'h0000, 0);
        for (int i = 0; i < FRAME; i++) step(0, 0, 0, 1, 16'h0700 + 16'(i), 0);
        chk("t4_imem_count", im_log_addr.size(), FRAME);
        if (im_log_addr.size() == FRAME) begin
            chk("t4_first_addr", im_log_addr[0], 0);
            chk("t4_last_addr", im_log_addr[FRAME-1], FRAME - 1);
        end
        step(0, 0, 0, 0, 16'h0000, 1);

        // Two strobes in one cycle: word dropped
        rst_step(0);
        step(1, 0, 0, 0, 16'h0008, 0);
        step(0, 1, 0, 0, 16'h0001, 0);
        clear_logs();
        step(0, 0, 1, 1, 16'h1234, 0);
        chk("t5_no_r0_we", r0_we, 0);
        chk("t5_no_imem_we", imem_we, 0);
        chk("t5_err", proto_err, ERR_EN);

        // Reset while R0 words are arriving
        rst_step(0);
        step(1, 0, 0, 0, 16'h0008, 0);
        step(0, 1, 0, 0, 16'h0003, 0);
        step(0, 0, 1, 0, 16'h1111, 0);
        clear_logs();
        rst_step(1);
        chk("t6_ready", core_ready, 1);
        chk("t6_reading", core_reading, 0);
        chk("t6_no_r0_we", r0_we, 0);
        step(0, 0, 1, 0, 16'h3333, 0);
        step(0, 0, 1, 0, 16'h4444, 0);
        chk("t6_no_late_r0", r0_log_addr.size(), 0);

        // Randomized frames with gaps, stray strobes, aborts and resets
        for (int f = 0; f < 250; f++) begin
            if (($urandom % 50) == 0) rst_step($urandom % 2);
            cm_word = 16'($urandom);
            cm_word[CORE_ID] = ($urandom % 10) < 7;
            send_frame(cm_word, 8'($urandom), 16'($urandom), 2, 1);
            gap(4);
            step(0, 0, 0, 0, 16'($urandom), 1);
        end

        core_mask_loading = 0; r0_mask_loading = 0; r0_loading = 0; instr_loading = 0;
        exec_done = 0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
